// File: rtl/wb_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx_pkg
// Brief    : Register offsets, STATUS bit indices and TX state encoding shared
//            by the Wishbone UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIVL   = 2'd2;
    localparam logic [1:0] REG_DIVH   = 2'd3;

    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_IRQ_EN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Brief    : Synchronous byte FIFO; pushes when full and pops when empty are
//            ignored. DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot
    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_tx
// Brief    : Wishbone I/O responder that buffers CPU bytes in a FIFO and sends
//            them as 8N1 frames. Define WB_UART_TX_IRQ_EN for the drain IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd86
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_tga_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        txd,
    output logic        irq
);

    logic                   w_req;
    logic                   w_cycle;
    logic                   w_wr;
    logic                   w_push;
    logic                   w_pop;
    logic [7:0]             w_rd_byte;
    logic [7:0]             w_status;
    logic                   r_ack;
    logic [15:0]            r_dat;
    logic [15:0]            r_div;
    logic                   r_ovf;
    logic                   w_irq_en;

    logic [7:0]             w_fifo_data;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [7:0]             r_shift;
    logic [7:0]             w_shift_nxt;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_nxt;
    logic [15:0]            r_baud;
    logic [15:0]            w_baud_nxt;
    logic                   r_txd;
    logic                   w_txd_nxt;
    logic                   w_busy;

    logic                   w_unused_bits;

    // One side effect per bus cycle: only the edge that raises ack acts
    assign w_req   = wb_stb_i & wb_cyc_i & wb_tga_i;
    assign w_cycle = w_req & ~r_ack;
    assign w_wr    = w_cycle & wb_we_i & wb_sel_i[0];
    assign w_push  = w_wr & (wb_adr_i == REG_TXDATA);
    assign w_busy  = (r_state != ST_IDLE);

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign txd      = r_txd;

    assign w_unused_bits = ^{wb_dat_i[15:8], wb_sel_i[1], w_fifo_count};

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .i_push  (w_push),
        .i_data  (wb_dat_i[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_status              = 8'h00;
        w_status[STAT_FULL]   = w_fifo_full;
        w_status[STAT_EMPTY]  = w_fifo_empty;
        w_status[STAT_BUSY]   = w_busy;
        w_status[STAT_OVF]    = r_ovf;
        w_status[STAT_IRQ_EN] = w_irq_en;
    end

    always_comb begin
        w_rd_byte = 8'h00;
        case (wb_adr_i)
            REG_STATUS: w_rd_byte = w_status;
            REG_DIVL:   w_rd_byte = r_div[7:0];
            REG_DIVH:   w_rd_byte = r_div[15:8];
            default:    w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack <= 1'b0;
            r_dat <= 16'h0000;
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
        end else begin
            r_ack <= w_cycle;
            if (w_cycle && !wb_we_i) begin
                r_dat <= {8'h00, w_rd_byte};
            end
            if (w_wr && (wb_adr_i == REG_DIVL)) begin
                r_div[7:0] <= wb_dat_i[7:0];
            end
            if (w_wr && (wb_adr_i == REG_DIVH)) begin
                r_div[15:8] <= wb_dat_i[7:0];
            end
            if (w_push && w_fifo_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (wb_adr_i == REG_STATUS) && wb_dat_i[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef WB_UART_TX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (wb_adr_i == REG_STATUS)) begin
                r_irq_en <= wb_dat_i[STAT_IRQ_EN];
            end
            r_irq <= r_irq_en & w_fifo_empty & ~w_busy;
        end
    end
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_shift <= 8'h00;
            r_idx   <= 3'd0;
            r_baud  <= 16'h0000;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_baud  <= w_baud_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Baud counter reloads from the live divisor at every bit start
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_baud_nxt  = r_baud;
        w_pop       = 1'b0;
        w_txd_nxt   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_baud_nxt  = r_div;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_txd_nxt = 1'b0;
                if (r_baud == 16'h0000) begin
                    w_baud_nxt  = r_div;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            ST_DATA: begin
                w_txd_nxt = r_shift[r_idx];
                if (r_baud == 16'h0000) begin
                    w_baud_nxt = r_div;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            ST_STOP: begin
                w_txd_nxt = 1'b1;
                if (r_baud == 16'h0000) begin
                    // Chain straight into the next frame so there is no idle gap
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_data;
                        w_baud_nxt  = r_div;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_tx
// Brief    : Self-checking bench for wb_uart_tx with a frame-level serial model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_tx;

    localparam int         c_depth  = 8;
    localparam logic [1:0] c_txdata = 2'd0;
    localparam logic [1:0] c_status = 2'd1;
    localparam logic [1:0] c_divl   = 2'd2;
    localparam logic [1:0] c_divh   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic [1:0]  adr;
    logic [1:0]  sel;
    logic        we;
    logic        tga;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        txd;
    logic        irq;

    int          n_checks = 0;
    int          n_err    = 0;
    logic        exp_irq_en;
    logic [15:0] rdv;
    logic [7:0]  rbyte;
    int          rdiv;
    int          cnt;

    always #5 clk = ~clk;

    wb_uart_tx #(
        .DEPTH     (c_depth),
        .DIV_RESET (16'd86)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_dat_i   (dat_i),
        .wb_dat_o   (dat_o),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_tga_i   (tga),
        .wb_stb_i   (stb),
        .wb_cyc_i   (cyc),
        .wb_ack_o   (ack),
        .txd        (txd),
        .irq        (irq)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic w, input logic [15:0] d,
                       input logic [1:0] s, output logic [15:0] r);
        int  lat;
        bit  got;
        @(posedge clk); #1;
        adr = a; we = w; dat_i = d; sel = s;
        stb = 1'b1; cyc = 1'b1; tga = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (ack) got = 1'b1;
        end
        r = dat_o;
        stb = 1'b0; cyc = 1'b0; tga = 1'b0; we = 1'b0;
        check("ack_latency", lat, 1);
        @(posedge clk); #1;
        check("ack_pulse", ack, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] r;
        bus(a, 1'b1, d, 2'b01, r);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] e, input string tag);
        logic [15:0] r;
        bus(a, 1'b0, 16'h0000, 2'b01, r);
        check(tag, r, e);
    endtask

    // Frame model: start 0, eight data bits LSB first, stop 1, each d+1 clocks
    task automatic send_frame(input logic [7:0] b, input int d);
        logic [9:0] bits;
        int         waited;
        bit         seen;
        bits = {1'b1, b, 1'b0};
        wr(c_txdata, {8'h00, b});
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            @(posedge clk); #1;
            waited++;
            if (txd === 1'b0) seen = 1'b1;
        end
        check("start_latency", waited, 1);
        for (int k = 0; k < 10 * (d + 1); k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check("txd_bit", txd, bits[k / (d + 1)]);
            check("irq_during_frame", irq, 0);
        end
        @(posedge clk); #1;
        check("irq_after_frame", irq, exp_irq_en);
    endtask

    task automatic wait_idle(input logic [15:0] e);
        logic [15:0] r;
        int          n;
        n = 0;
        r = 16'hFFFF;
        while (r !== e && n < 100) begin
            bus(c_status, 1'b0, 16'h0000, 2'b01, r);
            n++;
        end
        check("drain_status", r, e);
    endtask

    task automatic burst(input int n);
        int acks;
        int cycles;
        @(posedge clk); #1;
        adr = c_txdata; we = 1'b1; sel = 2'b01; dat_i = 16'($urandom) & 16'h00FF;
        stb = 1'b1; cyc = 1'b1; tga = 1'b1;
        acks   = 0;
        cycles = 0;
        while (acks < n && cycles < 4 * n) begin
            @(posedge clk); #1;
            cycles++;
            if (ack) begin
                acks++;
                dat_i = 16'($urandom) & 16'h00FF;
            end
        end
        stb = 1'b0; cyc = 1'b0; tga = 1'b0; we = 1'b0;
        check("burst_acks", acks, n);
        check("burst_cycles", cycles, 2 * n - 1);
    endtask

    task automatic quiet_line(input int n, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        dat_i = 16'h0000; adr = 2'd0; sel = 2'b00; we = 1'b0;
        tga = 1'b0; stb = 1'b0; cyc = 1'b0;
        exp_irq_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_ack", ack, 0);
        check("rst_dat", dat_o, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;

        rd_chk(c_status, 16'h0002, "status_reset");
        rd_chk(c_divl,   16'd86,   "divl_reset");
        rd_chk(c_divh,   16'h0000, "divh_reset");
        rd_chk(c_txdata, 16'h0000, "txdata_read");
        wr(c_divh, 16'hFF12);
        rd_chk(c_divh, 16'h0012, "divh_rw");
        wr(c_divh, 16'h0000);

        wr(c_divl, 16'h0003);
        rd_chk(c_divl, 16'h0003, "divl_rw");
        send_frame(8'hA5, 3);
        rd_chk(c_status, 16'h0002, "status_after_frame");

        wr(c_txdata, 16'h003C);
        rd_chk(c_status, 16'h0006, "status_busy");
        wait_idle(16'h0002);

        repeat (4) begin
            rdiv  = $urandom_range(0, 5);
            rbyte = 8'($urandom);
            wr(c_divl, 16'(rdiv));
            send_frame(rbyte, rdiv);
        end

        wr(c_divl, 16'h0000);
        send_frame(8'h01, 0);
        burst(2 * c_depth);
        bus(c_status, 1'b0, 16'h0000, 2'b01, rdv);
        check("ovf_set", rdv[3], 1);
        wr(c_status, 16'h0008);
        bus(c_status, 1'b0, 16'h0000, 2'b01, rdv);
        check("ovf_clear", rdv[3], 0);
        wait_idle(16'h0002);

        @(posedge clk); #1;
        adr = c_txdata; we = 1'b1; sel = 2'b01; dat_i = 16'h0055;
        stb = 1'b1; cyc = 1'b1; tga = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack) cnt++;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check("tga0_no_ack", cnt, 0);
        quiet_line(15, "tga0_no_frame");
        rd_chk(c_status, 16'h0002, "tga0_status");

        bus(c_txdata, 1'b1, 16'h0055, 2'b10, rdv);
        quiet_line(15, "sel_hi_no_frame");
        rd_chk(c_status, 16'h0002, "sel_hi_status");

        wr(c_divl, 16'h0003);
        wr(c_txdata, 16'h0000);
        repeat (8) @(posedge clk);
        #1;
        check("mid_data_txd", txd, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_txd", txd, 1);
        check("async_rst_ack", ack, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet_line(20, "frame_abandoned");
        rd_chk(c_status, 16'h0002, "status_after_reset");
        rd_chk(c_divl,   16'd86,   "divl_after_reset");

        wr(c_divl, 16'h0001);
`ifdef WB_UART_TX_IRQ_EN
        exp_irq_en = 1'b1;
        wr(c_status, 16'h0010);
        rd_chk(c_status, 16'h0012, "irq_en_status");
        @(posedge clk); #1;
        check("irq_idle_enabled", irq, 1);
`else
        exp_irq_en = 1'b0;
        wr(c_status, 16'h0010);
        rd_chk(c_status, 16'h0002, "irq_en_ignored");
        @(posedge clk); #1;
        check("irq_tied_low", irq, 0);
`endif
        send_frame(8'($urandom), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
